// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared digit codes and polarities for the display front end
//
// Purpose: constants shared by the display-path blocks (formatters, selector, scanner).
//   DIGIT_BLANK   digit code the segment driver renders as all segments off
//   DIGIT_DASH    digit code the segment driver renders as a single dash
//   POINT_OFF     point-mask bit value that turns a decimal point off
//   press_latch_e edge latch for a level button (armed / waiting for release)

package display_pkg;

    localparam logic [3:0] DIGIT_BLANK = 4'hF;
    localparam logic [3:0] DIGIT_DASH  = 4'hA;
    localparam logic       POINT_OFF   = 1'b1;

    typedef enum logic {
        LATCH_RELEASED = 1'b0,
        LATCH_PRESSED  = 1'b1
    } press_latch_e;

endpackage

// File: rtl/page_advance_search.sv
// rtl/page_advance_search.sv - find the next valid page after a given page, with wrap
//
// Purpose: combinational search upward from page_idx+1, wrapping NUM_PAGES-1 -> 0,
//   stopping before page_idx itself.
// Ports:
//   page_valid  in   NUM_PAGES  bit p = page p selectable
//   page_idx    in   PW         search start (excluded from the search)
//   next_idx    out  PW         nearest valid page after page_idx, else page_idx
//   found       out  1          1 = some page other than page_idx is valid

module page_advance_search #(
    parameter int NUM_PAGES = 4,
    parameter int PW        = $clog2(NUM_PAGES)
) (
    input  logic [NUM_PAGES-1:0] page_valid,
    input  logic [PW-1:0]        page_idx,
    output logic [PW-1:0]        next_idx,
    output logic                 found
);

    // Walk offsets from farthest to nearest so the nearest valid page wins.
    always_comb begin
        int cand;
        next_idx = page_idx;
        found    = 1'b0;
        cand     = 0;
        for (int k = NUM_PAGES - 1; k >= 1; k--) begin
            cand = int'(page_idx) + k;
            if (cand >= NUM_PAGES) begin
                cand = cand - NUM_PAGES;
            end
            if (page_valid[cand]) begin
                next_idx = PW'(cand);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/display_page_selector.sv
// rtl/display_page_selector.sv - page selector for the 8-digit seven-segment front end
//
// Purpose: holds NUM_PAGES pre-formatted digit pages and drives the selected one to the
//   segment scanner. Enter steps to the next valid page; optional auto-rotate dwell.
// Ports:
//   clk           in   1                        system clock
//   reset         in   1                        asynchronous, active-high
//   active        in   1                        display granted to this block
//   enter_button  in   1                        debounced level, 1 = pressed
//   auto_en       in   1                        auto-rotate every DWELL_CYCLES
//   page_valid    in   NUM_PAGES                bit p = page p selectable
//   page_digits   in   NUM_PAGES*NUM_DIGITS*4   page p digit d at [(p*NUM_DIGITS+d)*4 +: 4]
//   page_point    in   NUM_PAGES*NUM_DIGITS     page p point mask at [p*NUM_DIGITS +: NUM_DIGITS]
//   led_number    out  NUM_DIGITS*4             digit d at [d*4 +: 4], digit 0 rightmost
//   point         out  NUM_DIGITS               point mask of shown page (1 = off)
//   which_shine   out  NUM_DIGITS               always 0
//   is_shine      out  1                        always 0
//   page_idx      out  PW                       index of page currently shown

module display_page_selector
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int NUM_PAGES    = 4,
    parameter int DWELL_CYCLES = 50000000,
    localparam int PW          = $clog2(NUM_PAGES)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              active,
    input  logic                              enter_button,
    input  logic                              auto_en,
    input  logic [NUM_PAGES-1:0]              page_valid,
    input  logic [NUM_PAGES*NUM_DIGITS*4-1:0] page_digits,
    input  logic [NUM_PAGES*NUM_DIGITS-1:0]   page_point,
    output logic [NUM_DIGITS*4-1:0]           led_number,
    output logic [NUM_DIGITS-1:0]             point,
    output logic [NUM_DIGITS-1:0]             which_shine,
    output logic                              is_shine,
    output logic [PW-1:0]                     page_idx
);

    localparam int              DWW        = $clog2(DWELL_CYCLES);
    localparam logic [DWW-1:0]  DWELL_LAST = DWW'(DWELL_CYCLES - 1);
    localparam logic [PW-1:0]   LAST_PAGE  = PW'(NUM_PAGES - 1);

    press_latch_e              latch;
    logic                      active_q;
    logic [DWW-1:0]            dwell;

    logic [PW-1:0]             adv_idx;
    logic                      adv_found;
    logic [PW-1:0]             wrap_idx;
    logic                      wrap_found;
    logic [PW-1:0]             step_idx;
    logic [PW-1:0]             entry_idx;

    logic                      press_now;
    logic                      dwell_expired;
    logic                      shown_invalid;
    logic                      do_advance;

    logic [NUM_DIGITS*4-1:0]   led_next;
    logic [NUM_DIGITS-1:0]     point_next;

    assign which_shine = '0;
    assign is_shine    = 1'b0;

    page_advance_search #(
        .NUM_PAGES (NUM_PAGES),
        .PW        (PW)
    ) u_adv_search (
        .page_valid (page_valid),
        .page_idx   (page_idx),
        .next_idx   (adv_idx),
        .found      (adv_found)
    );

    // Searching "after the last page" scans 0..NUM_PAGES-2; the last page itself is
    // picked up separately, giving the first valid page counting from 0.
    page_advance_search #(
        .NUM_PAGES (NUM_PAGES),
        .PW        (PW)
    ) u_entry_search (
        .page_valid (page_valid),
        .page_idx   (LAST_PAGE),
        .next_idx   (wrap_idx),
        .found      (wrap_found)
    );

    always_comb begin
        step_idx  = adv_found ? adv_idx : page_idx;
        entry_idx = page_idx;
        if (wrap_found) begin
            entry_idx = wrap_idx;
        end else if (page_valid[NUM_PAGES-1]) begin
            entry_idx = LAST_PAGE;
        end
    end

    // Press, dwell expiry and a vanished page all collapse into one advance.
    always_comb begin
        press_now     = (latch == LATCH_RELEASED) && enter_button;
        dwell_expired = auto_en && (dwell == DWELL_LAST);
        shown_invalid = !page_valid[page_idx];
        do_advance    = active && active_q && (press_now || dwell_expired || shown_invalid);
    end

    always_comb begin
        led_next   = {NUM_DIGITS{DIGIT_BLANK}};
        point_next = {NUM_DIGITS{POINT_OFF}};
        if (|page_valid) begin
            led_next   = page_digits[int'(page_idx)*NUM_DIGITS*4 +: NUM_DIGITS*4];
            point_next = page_point[int'(page_idx)*NUM_DIGITS +: NUM_DIGITS];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            page_idx   <= '0;
            latch      <= LATCH_RELEASED;
            dwell      <= '0;
            active_q   <= 1'b0;
            led_number <= {NUM_DIGITS{DIGIT_BLANK}};
            point      <= {NUM_DIGITS{POINT_OFF}};
        end else begin
            active_q   <= active;
            led_number <= led_next;
            point      <= point_next;
            if (active && !active_q) begin
                // Entry: start from the first valid page; a button already held
                // when the display is granted must be released before it counts.
                page_idx <= entry_idx;
                latch    <= LATCH_PRESSED;
                dwell    <= '0;
            end else if (active) begin
                if (do_advance) begin
                    page_idx <= step_idx;
                    dwell    <= '0;
                end else if (auto_en) begin
                    dwell <= dwell + 1'b1;
                end else begin
                    dwell <= '0;
                end
                latch <= enter_button ? LATCH_PRESSED : LATCH_RELEASED;
            end else begin
                dwell <= '0;
            end
        end
    end

endmodule
